// File: rtl/ipv4_rx.sv
// IPv4 receive stage: parses the 20-byte header from the MAC payload stream,
// filters on version/IHL/checksum/protocol/destination and forwards the L4 payload.
module ipv4_rx #(
    parameter int         DATA_W = 16,
    parameter int         KEEP_W = DATA_W/8,
    parameter logic [7:0] PROTO  = 8'd17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic              last_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [KEEP_W-1:0] keep_i,
    input  logic              crc_err_i,
    input  logic [31:0]       ip_addr_i,
    output logic              valid_o,
    output logic              start_o,
    output logic              last_o,
    output logic [DATA_W-1:0] data_o,
    output logic [KEEP_W-1:0] keep_o,
    output logic [31:0]       src_addr_o,
    output logic              err_o
);

    typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD, DRAIN} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] csum;
    logic [7:0]  ver_ihl;
    logic [15:0] tot_len;
    logic [7:0]  proto;
    logic [31:0] src;
    logic [15:0] dst_hi;
    logic [15:0] rem;
    logic        bad;
    logic        first;

    logic [15:0]       word;
    logic [16:0]       sum;
    logic [15:0]       csum_next;
    logic              hdr_ok;
    logic [KEEP_W-1:0] mask;
    logic              last_pay;
    logic [15:0]       rem_next;
    logic              trunc;

    // Header words are big-endian; data_i[7:0] is the earlier byte on the wire.
    assign word      = {data_i[7:0], data_i[15:8]};
    assign sum       = {1'b0, csum} + {1'b0, word};
    assign csum_next = sum[15:0] + {15'd0, sum[16]};
    assign hdr_ok    = (ver_ihl == 8'h45) && (csum_next == 16'hFFFF) && (proto == PROTO) &&
                       ({dst_hi, word} == ip_addr_i) && (tot_len >= 16'd20);

    assign mask      = (rem >= 16'd2) ? 2'b11 : 2'b01;
    assign last_pay  = (rem <= 16'd2);
    assign rem_next  = (rem >= 16'd2) ? rem - 16'd2 : 16'd0;
    // Frame ended with fewer bytes than the IPv4 total length still owed.
    assign trunc     = last_i && ((rem > 16'd2) || ((rem == 16'd2) && !keep_i[1]));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            csum       <= '0;
            ver_ihl    <= '0;
            tot_len    <= '0;
            proto      <= '0;
            src        <= '0;
            dst_hi     <= '0;
            rem        <= '0;
            bad        <= 1'b0;
            first      <= 1'b0;
            valid_o    <= 1'b0;
            start_o    <= 1'b0;
            last_o     <= 1'b0;
            data_o     <= '0;
            keep_o     <= '0;
            src_addr_o <= '0;
            err_o      <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            start_o <= 1'b0;
            last_o  <= 1'b0;
            keep_o  <= '0;
            err_o   <= 1'b0;
            if (valid_i) begin
                if (start_i) begin
                    // An open downstream frame is closed with an empty last beat.
                    if (state == PAYLOAD) begin
                        valid_o <= 1'b1;
                        last_o  <= 1'b1;
                        data_o  <= '0;
                        err_o   <= 1'b1;
                    end
                    csum    <= word;
                    cnt     <= 4'd1;
                    ver_ihl <= word[15:8];
                    bad     <= 1'b0;
                    first   <= 1'b1;
                    if (last_i) begin
                        state <= IDLE;
                        err_o <= 1'b1;
                    end else begin
                        state <= HEAD;
                    end
                end else begin
                    case (state)
                        IDLE: ;
                        HEAD: begin
                            csum <= csum_next;
                            cnt  <= cnt + 4'd1;
                            case (cnt)
                                4'd1: tot_len    <= word;
                                4'd4: proto      <= word[7:0];
                                4'd6: src[31:16] <= word;
                                4'd7: src[15:0]  <= word;
                                4'd8: dst_hi     <= word;
                                default: ;
                            endcase
                            if (last_i) begin
                                state <= IDLE;
                                err_o <= !((cnt == 4'd9) && hdr_ok && (tot_len == 16'd20) && !crc_err_i);
                            end else if (cnt == 4'd9) begin
                                if (hdr_ok) begin
                                    rem   <= tot_len - 16'd20;
                                    state <= (tot_len == 16'd20) ? DRAIN : PAYLOAD;
                                end else begin
                                    bad   <= 1'b1;
                                    state <= DRAIN;
                                end
                            end
                        end
                        PAYLOAD: begin
                            valid_o <= 1'b1;
                            start_o <= first;
                            first   <= 1'b0;
                            data_o  <= data_i;
                            if (first) src_addr_o <= src;
                            keep_o  <= last_i ? (keep_i & mask) : mask;
                            last_o  <= last_i || last_pay;
                            rem     <= rem_next;
                            if (last_i) begin
                                state <= IDLE;
                                err_o <= crc_err_i || trunc;
                            end else if (last_pay) begin
                                state <= DRAIN;
                            end
                        end
                        DRAIN: begin
                            if (last_i) begin
                                state <= IDLE;
                                err_o <= bad || crc_err_i;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/ipv4_rx.md
Name: ipv4_rx

Overview:
- IPv4 receive stage, directly downstream of the MAC receive block.
- Consumes the MAC payload stream (Ethernet header already stripped, FCS checked) and parses the 20-byte IPv4 header.
- Verifies version, IHL, header checksum, destination address and protocol, then forwards the trimmed L4 payload to the transport layer.
- Flags bad or truncated datagrams.

Parameters:
- DATA_W, 16, data bus width in bits; only 16 is supported.
- KEEP_W, DATA_W/8, byte-enable width.
- PROTO, 8'd17, accepted IPv4 protocol number (UDP).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- valid_i  input  1  input beat valid
- start_i  input  1  first beat of a MAC payload, qualified by valid_i
- last_i  input  1  final beat of the MAC payload, qualified by valid_i
- data_i  input  DATA_W  payload bytes; data_i[7:0] is the earlier byte on the wire
- keep_i  input  KEEP_W  byte enables; only meaningful on last_i
- crc_err_i  input  1  MAC FCS error, qualified by valid_i & last_i
- ip_addr_i  input  32  local IPv4 address, network order, static during a frame
- valid_o  output  1  output payload beat valid
- start_o  output  1  first payload beat
- last_o  output  1  last payload beat (as given by IPv4 total length)
- data_o  output  DATA_W  payload data, same byte order as input
- keep_o  output  KEEP_W  byte enables
- src_addr_o  output  32  source address of the current datagram, stable from start_o until the next start_o
- err_o  output  1  one-cycle pulse: the datagram just ended was bad; downstream discards it

Behaviour:
- **Reset:** synchronous, active-high. All outputs 0, FSM in IDLE, accumulators cleared.
- **Latency and flow:** every output is registered; latency is 1 cycle from input beat to output beat. There is no backpressure.
- **Header words:** the header is 10 beats. Each header word is {data_i[7:0], data_i[15:8]} (network order).
- **FSM states:** IDLE, HEAD, PAYLOAD, DRAIN.
  - IDLE: valid_i & start_i → HEAD. This beat is header word 0. The header beat counter is set to 1 and the checksum is seeded.
  - HEAD: accumulate each beat. Capture these fields:
    - version/IHL from word 0.
    - total length from word 1.
    - protocol from word 4 low byte.
    - source address from words 6–7.
    - destination address from words 8–9.
  - HEAD, on the 10th beat: evaluate hdr_ok.
    - hdr_ok requires version==4, IHL==5, final checksum==16'hFFFF, protocol==PROTO, destination==ip_addr_i, and total length ≥ 20.
    - hdr_ok → PAYLOAD with rem = total_len − 20. If rem==0 → DRAIN.
    - !hdr_ok → DRAIN with the error flag set.
  - PAYLOAD: forward each beat.
    - keep_o = 2'b11 while rem ≥ 2. When rem == 1, keep_o = 2'b01 and last_o = 1.
    - rem decrements by the bytes forwarded.
    - When rem reaches 0 and last_i is not yet seen → DRAIN. MAC padding is dropped silently.
  - DRAIN: discard beats until valid_i & last_i, then → IDLE.
- **Checksum:** 17-bit accumulator with end-around carry folded every beat, so the sum stays 16 bits.
- **Error and end-of-frame handling:**
  - err_o pulses one cycle after the input beat carrying last_i when any of these holds: header rejected, crc_err_i set, or last_i arrived before rem reached 0 (truncation).
  - On truncation, the beat carrying last_i is forwarded with last_o=1 and keep_o=keep_i & rem mask, so the downstream frame is always closed.
  - last_i while in HEAD → error pulse, no output beats, → IDLE.
  - Header-rejected datagrams emit no output beats.
  - A good frame emits no err_o.
- **start_i mid-frame:** the current frame is aborted.
  - If payload has been emitted, the abort produces err_o and a zero-keep last_o beat.
  - The new frame's header parse starts on that same beat.
- **valid_i low:** no state change, counters hold.
- **Reset mid-frame:** immediately returns to IDLE; no err_o is emitted.

Test Plan:
- **Good UDP datagram:** valid header, total_len=0x0020, 12 payload bytes, dst==ip_addr_i, no padding → 6 output beats; start_o on the first, last_o on the 6th with keep_o=2'b11; err_o never set; src_addr_o = header source address.
- **Odd length with MAC padding:** total_len=0x001F (11 payload bytes), MAC frame padded to 46 bytes → 6 output beats, last_o with keep_o=2'b01; the pad beats produce no valid_o; no err_o.
- **Checksum error:** header checksum field off by 1 → no valid_o; err_o pulses once, one cycle after last_i.
- **Filter rejects:** protocol=6 (TCP), or dst=ip_addr_i+1, or IHL=6 → no output beats; err_o pulse.
- **FCS and truncation:** good header with crc_err_i at last_i → payload forwarded, then err_o pulse. Separately, total_len=0x0040 but last_i after 10 payload bytes → last_o on that beat, err_o pulse.
- **Back-to-back frames and reset:** two back-to-back frames with valid_i gaps → both delivered intact. Assert reset during PAYLOAD → all outputs 0 next cycle; the next start_i is parsed normally.
